// File: rtl/door_pkg.sv
// Shared types and sizing helpers for the car-door sequencer.
// Optional nudge mode is enabled by defining DOOR_NUDGE_EN.
package door_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED    = 3'b000,
        ST_OPENING   = 3'b001,
        ST_OPEN_HOLD = 3'b010,
        ST_CLOSING   = 3'b011,
        ST_FAULT     = 3'b100
    } state_t;

    localparam int HOLD_CYCLES_DEF    = 8;
    localparam int TRAVEL_TIMEOUT_DEF = 6;
    localparam int MAX_REOPEN_DEF     = 2;

    function automatic int timer_w(input int h, input int t);
        return $clog2((h > t) ? h : t);
    endfunction

    function automatic int reopen_w(input int m);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/door_if.sv
// Door sensor/actuator bundle between the door sequencer and its environment.
// master drives requests and switches; slave is the sequencer side.
interface door_if;
    logic       open_req;
    logic       close_req;
    logic       motor_on;
    logic       obstruction;
    logic       open_limit;
    logic       closed_limit;
    logic       door_open_drive;
    logic       door_close_drive;
    logic       doors_closed;
    logic       door_fault;
    logic       nudge_buzzer;
    logic [2:0] door_state;

    modport master (
        output open_req, close_req, motor_on,
        output obstruction, open_limit, closed_limit,
        input  door_open_drive, door_close_drive,
        input  doors_closed, door_fault,
        input  nudge_buzzer, door_state
    );

    modport slave (
        input  open_req, close_req, motor_on,
        input  obstruction, open_limit, closed_limit,
        output door_open_drive, door_close_drive,
        output doors_closed, door_fault,
        output nudge_buzzer, door_state
    );
endinterface

// File: rtl/door_timer.sv
// Loadable down-counter that saturates at zero and flags it.
// Reset loads RST_VAL so the first state already has a running budget.
module door_timer #(
    parameter int          W       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/door_controller.sv
// Car-door sequencer producing doors_closed for the lift motion FSM.
// Define DOOR_NUDGE_EN to force a buzzer-warned close after MAX_REOPEN reopens.
module door_controller
    import door_pkg::*;
#(
    parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
    parameter int TRAVEL_TIMEOUT = TRAVEL_TIMEOUT_DEF,
    parameter int MAX_REOPEN     = MAX_REOPEN_DEF
) (
    input  logic clk,
    input  logic reset,
    door_if.slave dif
);

    localparam int TW = timer_w(HOLD_CYCLES, TRAVEL_TIMEOUT);
    localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_TIMEOUT - 1);

    if (HOLD_CYCLES < 2 || TRAVEL_TIMEOUT < 2 || MAX_REOPEN < 1) begin : g_bad_cfg
        $error("door_controller: parameter out of range");
    end

    state_t        state_q, state_d;
    logic          t_load;
    logic [TW-1:0] t_val;
    logic          t_zero;
    logic          nudge;

`ifdef DOOR_NUDGE_EN
    localparam int CW = reopen_w(MAX_REOPEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_REOPEN);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          nudge_q, nudge_d;

    // Nudge is decided once, on entry to CLOSING, and held for that pass.
    always_comb begin
        cnt_d   = cnt_q;
        nudge_d = 1'b0;
        if (state_q == ST_CLOSING && state_d == ST_CLOSED) begin
            cnt_d = '0;
        end else if (state_q == ST_CLOSING && state_d == ST_OPENING
                     && dif.obstruction) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
        if (state_d == ST_CLOSING) begin
            nudge_d = (state_q == ST_CLOSING) ? nudge_q : (cnt_q == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            nudge_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            nudge_q <= nudge_d;
        end
    end

    assign nudge = nudge_q;
`else
    assign nudge = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CLOSED: begin
                if (dif.open_req && !dif.motor_on) state_d = ST_OPENING;
            end
            ST_OPENING: begin
                if (dif.open_limit)  state_d = ST_OPEN_HOLD;
                else if (t_zero)     state_d = ST_FAULT;
            end
            ST_OPEN_HOLD: begin
                if (dif.obstruction || dif.open_req) state_d = ST_OPEN_HOLD;
                else if (dif.close_req)              state_d = ST_CLOSING;
                else if (t_zero)                     state_d = ST_CLOSING;
            end
            ST_CLOSING: begin
                if (!nudge && dif.obstruction)
                    state_d = ST_OPENING;
                else if (!nudge && dif.open_req && !dif.motor_on)
                    state_d = ST_OPENING;
                else if (dif.closed_limit)
                    state_d = ST_CLOSED;
                else if (t_zero)
                    state_d = ST_FAULT;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLOSING;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold reloads on every request seen while open, not only on entry.
    assign t_load = (state_d != state_q)
                  || (state_q == ST_OPEN_HOLD
                      && (dif.obstruction || dif.open_req));
    assign t_val  = (state_d == ST_OPEN_HOLD) ? HOLD_LD : TRAVEL_LD;

    door_timer #(
        .W       (TW),
        .RST_VAL (TRAVEL_LD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_comb begin
        dif.door_open_drive  = 1'b0;
        dif.door_close_drive = 1'b0;
        dif.doors_closed     = 1'b0;
        dif.door_fault       = 1'b0;
        dif.nudge_buzzer     = 1'b0;
        dif.door_state       = state_q;
        unique case (state_q)
            ST_CLOSED:  dif.doors_closed = 1'b1;
            ST_OPENING: dif.door_open_drive = 1'b1;
            ST_CLOSING: begin
                dif.door_close_drive = 1'b1;
                dif.nudge_buzzer     = nudge;
            end
            ST_FAULT:   dif.door_fault = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: doc/door_controller.md
Name: door_controller

Overview:
- Car-door sequencer directly upstream of the lift motion FSM; produces the `doors_closed` qualifier that FSM waits on in its Starting_up/Starting_down states.
- Drives the door motor open/close and enforces hold time, obstruction reopen, travel timeouts and a latched fault.
- Blocks door opening while the lift motor is running.

Parameters:
- HOLD_CYCLES, 8, cycles doors stay fully open before auto-close (≥2).
- TRAVEL_TIMEOUT, 6, max cycles from entering OPENING/CLOSING to the matching limit switch (≥2).
- MAX_REOPEN, 2, obstruction reopens allowed before nudge (used only with DOOR_NUDGE_EN).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- open_req  in  1  level; request doors open (hall/car button or floor arrival).
- close_req  in  1  level; request early close; tie to the FSM "starting" states.
- motor_on  in  1  lift motor running (from motion FSM); inhibits open_req.
- obstruction  in  1  door-edge sensor.
- open_limit  in  1  doors fully open.
- closed_limit  in  1  doors fully closed.
- door_open_drive  out  1  door motor open command.
- door_close_drive  out  1  door motor close command.
- doors_closed  out  1  doors closed and locked; feeds the motion FSM.
- door_fault  out  1  latched fault.
- nudge_buzzer  out  1  nudge warning (constant 0 without DOOR_NUDGE_EN).
- door_state  out  3  current state, for debug.

Behaviour:
- Interface: one clock `clk`. `reset` is synchronous and active-high.
- Reset:
  - state ← CLOSING, timer ← TRAVEL_TIMEOUT-1, reopen_cnt ← 0.
  - Outputs during and after reset: close_drive=1, open_drive=0, doors_closed=0, door_fault=0, nudge_buzzer=0, door_state=3'b011.
- Outputs: Moore decode of the registered state.
- Reset mid-operation: any state, including FAULT, returns to CLOSING on the next edge.
- States:
  - CLOSED=000: doors_closed=1, no drives.
  - OPENING=001: open_drive=1.
  - OPEN_HOLD=010: no drives.
  - CLOSING=011: close_drive=1.
  - FAULT=100: door_fault=1, no drives.
- Timer: one shared down-counter.
  - Loaded on every state entry: TRAVEL_TIMEOUT-1 for OPENING/CLOSING, HOLD_CYCLES-1 for OPEN_HOLD.
  - Decrements each cycle; saturates at 0.
- CLOSED:
  - open_req && !motor_on → OPENING.
  - Otherwise stay in CLOSED.
- OPENING:
  - open_limit → OPEN_HOLD.
  - Else timer==0 → FAULT.
  - A limit on the same cycle as timer==0 wins, so the limit must arrive within TRAVEL_TIMEOUT cycles of entry.
- OPEN_HOLD, priority order:
  - obstruction or open_req → reload HOLD_CYCLES-1, stay.
  - close_req → CLOSING.
  - timer==0 → CLOSING.
  - Dwell without requests is exactly HOLD_CYCLES cycles.
- CLOSING, priority order:
  1. obstruction → OPENING, reopen_cnt+1 (saturating at MAX_REOPEN).
  2. open_req && !motor_on → OPENING, count unchanged.
  3. closed_limit → CLOSED, reopen_cnt ← 0.
  4. timer==0 → FAULT.
  - Obstruction always beats closed_limit in the same cycle.
- FAULT: sticky; only reset exits.
- motor_on: affects only open_req gating. Obstruction reopen is never inhibited.
- open_limit and closed_limit asserted together: ignored except in the state expecting them.

Optional Feature:
- Macro: DOOR_NUDGE_EN.
- Defined:
  - When CLOSING is entered with reopen_cnt==MAX_REOPEN, the block is in nudge mode for that CLOSING pass.
  - In nudge mode, obstruction and open_req are ignored and nudge_buzzer=1.
  - Closing continues until closed_limit (→ CLOSED, count cleared) or timeout (→ FAULT).
- Undefined: obstruction always reopens, reopen_cnt logic is removed, nudge_buzzer is tied 0.

Decomposition:
- Package door_pkg holds:
  - state encodings (3-bit, values above);
  - timer width function `$clog2(max(HOLD_CYCLES,TRAVEL_TIMEOUT))`;
  - reopen counter width.
- Sub-module door_timer: loadable saturating down-counter with load value input, load strobe and zero flag; one instance.

Test Plan (defaults):
- Reset → door_state=011, close_drive=1. closed_limit at cycle 3 → CLOSED, doors_closed=1 next cycle.
- CLOSED, open_req pulse, open_limit 2 cycles later → OPEN_HOLD. Auto-close to CLOSING exactly 8 cycles later. closed_limit → CLOSED.
- CLOSED, motor_on=1 with open_req held 10 cycles → state stays 000, open_drive=0 throughout.
- CLOSING with obstruction and closed_limit in the same cycle → OPENING, reopen_cnt=1.
  - With DOOR_NUDGE_EN, after a second reopen the next CLOSING ignores obstruction and nudge_buzzer=1.
- OPENING without open_limit → FAULT on cycle 6 after entry, door_fault=1, drives 0. open_req ignored. reset → CLOSING.
- OPEN_HOLD, close_req at dwell cycle 2 → CLOSING next cycle. Same with obstruction also high → stays OPEN_HOLD, timer reloaded to 7.
